debug_trace_buffer: RTL and testbench
=====================================

DEBUG_TRACE_BUFFER -- requirements
Module: debug_trace_buffer

Interface
REQ-001 Parameter XLEN, default 32, sets the width of the PC, instruction and ALU-result fields.
REQ-002 Parameter DEPTH, default 16, sets the trace entries stored; it SHALL be a power of 2 and at least 4.
REQ-003 Parameter POST_DEPTH, default 8, sets the entries captured after the trigger; it SHALL satisfy 0 <= POST_DEPTH < DEPTH.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 commit_valid  in  1  one instruction retires this cycle.
REQ-008 pc_in / instr_in / alu_result_in  in  XLEN each  retiring instruction's PC, encoding and ALU result.
REQ-009 arm  in  1  single-cycle pulse that starts a capture session.
REQ-010 trig_en  in  1  enables the PC-match trigger.
REQ-011 trig_pc  in  XLEN  PC that fires the trigger.
REQ-012 rd_ready  in  1  consumer accepts the current read entry.
REQ-013 rd_valid  out  1  read entry present.
REQ-014 rd_pc / rd_instr / rd_alu  out  XLEN each  oldest stored entry.
REQ-015 entries  out  clog2(DEPTH)+1  count of stored entries.
REQ-016 state_o  out  2  current FSM state.
REQ-017 trig_hit  out  1  sticky trigger-fired flag.

Function
REQ-018 The FSM SHALL have four states: IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-019 IDLE: no capture; arm -> ARMED with wr_ptr=0, entries=0, trig_hit=0; a commit in the arm cycle is not captured.
REQ-020 ARMED: each commit_valid writes {pc,instr,alu} at wr_ptr; wr_ptr wraps modulo DEPTH; entries increments and saturates at DEPTH, where the oldest entry is overwritten.
REQ-021 In ARMED, commit_valid && trig_en && pc_in==trig_pc SHALL write the triggering entry, set trig_hit, load post_cnt=POST_DEPTH, and go to POST, or to DONE if POST_DEPTH=0.
REQ-022 POST: each commit is captured as in ARMED and decrements post_cnt; the commit that takes post_cnt to 0 is captured and the next state is DONE.
REQ-023 Trigger matches in POST or DONE SHALL be ignored.
REQ-024 DONE: no capture; rd_valid = (entries != 0).
REQ-025 In DONE, the read head is (wr_ptr - entries) mod DEPTH, i.e. oldest first.
REQ-026 Each rd_valid && rd_ready cycle SHALL pop one entry and decrement entries.
REQ-027 When entries reaches 0 in DONE, the next state is IDLE.
REQ-028 rd_valid SHALL be 0 in every state other than DONE, and rd_* data is don't-care when rd_valid=0.
REQ-029 Read data SHALL be combinational from the head entry, so an entry is readable in the cycle after it is written.
REQ-030 arm in ARMED or POST SHALL restart the session (clear pointers, count, trig_hit; state ARMED); any commit in that cycle is dropped.
REQ-031 arm in DONE SHALL be ignored.
REQ-032 trig_hit SHALL stay 1 from the trigger edge until the next arm or reset.
REQ-033 If trig_en is held low, ARMED SHALL capture indefinitely with no state change.

Reset
REQ-034 Asserting rst_n low SHALL immediately force state IDLE, wr_ptr=0, entries=0, post_cnt=0, trig_hit=0, rd_valid=0.
REQ-035 Storage array contents are not reset and are don't-care.
REQ-036 Reset mid-session or mid-readout SHALL discard all stored entries.

Structure
REQ-037 Package debug_pkg SHALL hold the state encoding constants and the trace-entry width constant (3*XLEN).
REQ-038 Sub-module trace_ram SHALL implement DEPTH x 3*XLEN storage with one synchronous write port and one asynchronous read port, with no reset.
REQ-039 The top level SHALL contain the FSM, pointers, counters and the trigger comparator.

Verification
REQ-040 Wrap test: arm, trig_en=0, 20 commits with PC=0x0,4,...,0x4C -> entries=16, state stays ARMED.
REQ-041 Trigger + post: DEPTH=16, POST_DEPTH=8, arm, trig_pc=0x40, commits PC 0x0..0x7C step 4 -> DONE after PC 0x60; readout yields 16 entries, PC 0x24..0x60 in order; state IDLE after last pop.
REQ-042 Backpressure: in DONE hold rd_ready=0 for 5 cycles -> rd_pc stable, entries unchanged; then rd_ready=1 for 3 cycles -> entries drops by 3.
REQ-043 POST_DEPTH=0: trigger on PC 0x10 -> DONE next cycle; last read entry has PC 0x10.
REQ-044 Re-arm: arm during POST -> state ARMED, entries=0, trig_hit=0; arm pulse in DONE -> no state change.
REQ-045 Async reset: drop rst_n mid-readout, off clock edge -> rd_valid=0, entries=0, state IDLE before the next edge.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the instruction trace buffer: FSM encoding and entry geometry.
package debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_t;

    localparam int unsigned FIELDS_PER_ENTRY = 3;

    // One entry packs {pc, instr, alu}, each XLEN wide.
    function automatic int unsigned entry_width(input int unsigned xlen);
        return FIELDS_PER_ENTRY * xlen;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: synchronous write, asynchronous read, contents never reset.
module trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/debug_trace_buffer.sv
// Circular retire-trace buffer with PC-match trigger, post-trigger capture and
// oldest-first readout.
module debug_trace_buffer
    import debug_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned POST_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     commit_valid,
    input  logic [XLEN-1:0]          pc_in,
    input  logic [XLEN-1:0]          instr_in,
    input  logic [XLEN-1:0]          alu_result_in,
    input  logic                     arm,
    input  logic                     trig_en,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [XLEN-1:0]          rd_pc,
    output logic [XLEN-1:0]          rd_instr,
    output logic [XLEN-1:0]          rd_alu,
    output logic [$clog2(DEPTH):0]   entries,
    output logic [1:0]               state_o,
    output logic                     trig_hit
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = entry_width(XLEN);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] POST_LD  = AW'(POST_DEPTH);
    localparam logic [AW-1:0] POST_ONE = AW'(1);

    trace_state_t  state, state_next;
    logic [AW-1:0] wr_ptr, wr_ptr_next;
    logic [AW:0]   cnt, cnt_next;
    logic [AW-1:0] post_cnt, post_next;
    logic          hit_next;
    logic          capture, trig_match, pop;
    logic [AW-1:0] rd_addr;
    logic [EW-1:0] rd_data;

    assign capture    = commit_valid && !arm && (state == ST_ARMED || state == ST_POST);
    assign trig_match = trig_en && (pc_in == trig_pc);
    assign rd_valid   = (state == ST_DONE) && (cnt != '0);
    assign pop        = rd_valid && rd_ready;
    // A full buffer has cnt low bits == 0, so the head lands on wr_ptr as required.
    assign rd_addr    = wr_ptr - cnt[AW-1:0];

    always_comb begin
        state_next  = state;
        wr_ptr_next = wr_ptr;
        cnt_next    = cnt;
        post_next   = post_cnt;
        hit_next    = trig_hit;
        if (capture) begin
            wr_ptr_next = wr_ptr + POST_ONE;
            if (cnt != CNT_FULL) begin
                cnt_next = cnt + CNT_ONE;
            end
        end
        unique case (state)
            ST_IDLE, ST_ARMED, ST_POST: begin
                if (arm) begin
                    state_next  = ST_ARMED;
                    wr_ptr_next = '0;
                    cnt_next    = '0;
                    post_next   = '0;
                    hit_next    = 1'b0;
                end else if (capture && state == ST_ARMED && trig_match) begin
                    hit_next   = 1'b1;
                    post_next  = POST_LD;
                    state_next = (POST_DEPTH == 0) ? ST_DONE : ST_POST;
                end else if (capture && state == ST_POST) begin
                    post_next = post_cnt - POST_ONE;
                    if (post_cnt == POST_ONE) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (pop) begin
                    cnt_next = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_next = ST_IDLE;
                    end
                end else if (cnt == '0) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wr_ptr   <= '0;
            cnt      <= '0;
            post_cnt <= '0;
            trig_hit <= 1'b0;
        end else begin
            state    <= state_next;
            wr_ptr   <= wr_ptr_next;
            cnt      <= cnt_next;
            post_cnt <= post_next;
            trig_hit <= hit_next;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk   (clk),
        .we    (capture),
        .waddr (wr_ptr),
        .wdata ({pc_in, instr_in, alu_result_in}),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign rd_pc    = rd_data[3*XLEN-1:2*XLEN];
    assign rd_instr = rd_data[2*XLEN-1:XLEN];
    assign rd_alu   = rd_data[XLEN-1:0];
    assign entries  = cnt;
    assign state_o  = state;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Self-checking bench: queue-based reference model plus directed scenarios and random traffic.
module tb_debug_trace_buffer;

    localparam int DEPTH = 16;
    localparam int POST  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        commit_valid = 1'b0;
    logic [31:0] pc_in = '0, instr_in = '0, alu_result_in = '0;
    logic        arm = 1'b0, trig_en = 1'b0;
    logic [31:0] trig_pc = '0;
    logic        rd_ready = 1'b0;

    logic        rd_valid, rd_valid0;
    logic [31:0] rd_pc, rd_instr, rd_alu, rd_pc0, rd_instr0, rd_alu0;
    logic [4:0]  entries, entries0;
    logic [1:0]  state_o, state_o0;
    logic        trig_hit, trig_hit0;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    debug_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .POST_DEPTH(POST)) u_dut (
        .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .pc_in(pc_in),
        .instr_in(instr_in), .alu_result_in(alu_result_in), .arm(arm), .trig_en(trig_en),
        .trig_pc(trig_pc), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc),
        .rd_instr(rd_instr), .rd_alu(rd_alu), .entries(entries), .state_o(state_o),
        .trig_hit(trig_hit)
    );

    debug_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .POST_DEPTH(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .pc_in(pc_in),
        .instr_in(instr_in), .alu_result_in(alu_result_in), .arm(arm), .trig_en(trig_en),
        .trig_pc(trig_pc), .rd_ready(rd_ready), .rd_valid(rd_valid0), .rd_pc(rd_pc0),
        .rd_instr(rd_instr0), .rd_alu(rd_alu0), .entries(entries0), .state_o(state_o0),
        .trig_hit(trig_hit0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue of captured commits plus a session phase
    // (0 idle, 1 armed, 2 post-trigger, 3 readout).
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
    } ent_t;

    ent_t mq[$];
    int   m_phase = 0;
    int   m_left = 0;
    bit   m_hit = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_phase = 0;
            m_left  = 0;
            m_hit   = 1'b0;
        end else if (m_phase == 3) begin
            if (mq.size() > 0 && rd_ready) void'(mq.pop_front());
            if (mq.size() == 0) m_phase = 0;
        end else if (arm) begin
            mq.delete();
            m_phase = 1;
            m_hit   = 1'b0;
        end else if (m_phase != 0 && commit_valid) begin
            mq.push_back('{pc: pc_in, instr: instr_in, alu: alu_result_in});
            if (mq.size() > DEPTH) void'(mq.pop_front());
            if (m_phase == 1 && trig_en && pc_in == trig_pc) begin
                m_hit   = 1'b1;
                m_left  = POST;
                m_phase = (POST == 0) ? 3 : 2;
            end else if (m_phase == 2) begin
                m_left--;
                if (m_left == 0) m_phase = 3;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("state", state_o, m_phase);
            chk("entries", entries, mq.size());
            chk("trig_hit", trig_hit, m_hit);
            chk("rd_valid", rd_valid, (m_phase == 3 && mq.size() > 0));
            if (m_phase == 3 && mq.size() > 0) begin
                chk("rd_pc", rd_pc, mq[0].pc);
                chk("rd_instr", rd_instr, mq[0].instr);
                chk("rd_alu", rd_alu, mq[0].alu);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc);
        commit_valid  = 1'b1;
        pc_in         = pc;
        instr_in      = $urandom;
        alu_result_in = $urandom;
        tick();
        commit_valid  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] held, last;

        repeat (2) tick();
        chk("reset_state", state_o, 0);
        chk("reset_entries", entries, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_trig_hit", trig_hit, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        tick();

        // Wrap with trigger disabled
        pulse_arm();
        for (int i = 0; i < 20; i++) commit(32'(4 * i));
        chk("wrap_entries", entries, 16);
        chk("wrap_state", state_o, 1);

        // Trigger at 0x40 with 8 post-trigger commits
        trig_en = 1'b1;
        trig_pc = 32'h40;
        pulse_arm();
        for (int i = 0; i < 32; i++) begin
            commit(32'(4 * i));
            if (i == 23) chk("post_state_0x5c", state_o, 2);
            if (i == 24) chk("done_state_0x60", state_o, 3);
        end
        rd_ready = 1'b0;
        held = rd_pc;
        chk("bp_head_pc", held, 32'h24);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_rd_pc_stable", rd_pc, held);
        end
        chk("bp_entries_held", entries, 16);
        rd_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 3; i++) begin
            chk("read_order", rd_pc, 32'(32'h24 + 4 * k));
            k++;
            tick();
        end
        chk("bp_entries_after3", entries, 13);
        for (int i = 0; i < 40 && rd_valid; i++) begin
            chk("read_order", rd_pc, 32'(32'h24 + 4 * k));
            k++;
            tick();
        end
        chk("read_count", k, 16);
        chk("idle_after_drain", state_o, 0);
        rd_ready = 1'b0;

        // POST_DEPTH=0 instance: trigger on 0x10 goes straight to readout
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        trig_pc = 32'h10;
        pulse_arm();
        for (int i = 0; i < 5; i++) commit(32'(4 * i));
        chk("p0_state_done", state_o0, 3);
        chk("p0_entries", entries0, 5);
        rd_ready = 1'b1;
        k = 0;
        last = '0;
        for (int i = 0; i < 20 && rd_valid0; i++) begin
            last = rd_pc0;
            k++;
            tick();
        end
        chk("p0_read_count", k, 5);
        chk("p0_last_pc", last, 32'h10);
        rd_ready = 1'b0;

        // Re-arm during POST, then arm ignored in DONE
        chk("rearm_pre_post", state_o, 2);
        pulse_arm();
        chk("rearm_state", state_o, 1);
        chk("rearm_entries", entries, 0);
        chk("rearm_hit", trig_hit, 0);
        trig_pc = 32'h100;
        commit(32'h100);
        for (int i = 1; i <= POST; i++) commit(32'(32'h100 + 4 * i));
        chk("rearm_done", state_o, 3);
        pulse_arm();
        chk("arm_in_done_state", state_o, 3);
        chk("arm_in_done_entries", entries, 9);
        rd_ready = 1'b1;
        for (int i = 0; i < 40 && state_o != 0; i++) tick();
        chk("rearm_drained", state_o, 0);

        // Random traffic
        trig_pc = 32'h20;
        for (int i = 0; i < 3000; i++) begin
            arm           = ($urandom_range(39) == 0);
            commit_valid  = $urandom_range(1);
            pc_in         = 32'(4 * $urandom_range(15));
            instr_in      = $urandom;
            alu_result_in = $urandom;
            trig_en       = ($urandom_range(9) < 7);
            rd_ready      = $urandom_range(1);
            tick();
        end
        arm = 1'b0;
        commit_valid = 1'b0;
        rd_ready = 1'b0;

        // Asynchronous reset during readout
        trig_en = 1'b1;
        for (int i = 0; i < 40 && state_o != 0; i++) begin
            rd_ready = 1'b1;
            tick();
        end
        rd_ready = 1'b0;
        pulse_arm();
        commit(32'h20);
        for (int i = 0; i < POST; i++) commit(32'h200);
        chk("ar_done", state_o, 3);
        rd_ready = 1'b1;
        tick();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rd_valid", rd_valid, 0);
        chk("ar_entries", entries, 0);
        chk("ar_state", state_o, 0);
        rd_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
